// File: rtl/bullet_pkg.sv
// Shared types and width helpers for the bullet slot scheduler.
package bullet_pkg;

    localparam int COORD_W = 10;
    localparam int OWNER_W = 4;

    typedef logic [OWNER_W-1:0] owner_t;

    localparam owner_t OWNER_PLAYER = '0;

    // Index width that stays at least one bit for single-entry pools.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or above ptr (wrapping), plus the pointer after it.
module rr_arbiter
    import bullet_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [N-1:0]          gnt,
    output logic [idx_w(N)-1:0]   next_ptr,
    output logic                  any
);

    localparam int PW = idx_w(N);

    always_comb begin
        int idx;
        idx      = 0;
        gnt      = '0;
        next_ptr = ptr;
        any      = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                next_ptr = (idx + 1 >= N) ? '0 : PW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/bullet_scheduler.sv
// Bullet slot allocator: player-priority, round-robin enemies, one launch per frame.
// Define BULLET_COOLDOWN_EN to build the player cooldown counter.
module bullet_scheduler
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int NUM_ENEMY       = 3,
    parameter int PLAYER_MAX_LIVE = 1,
    parameter int PLAYER_COOLDOWN = 8
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic                           player_req,
    input  logic [COORD_W-1:0]             player_x,
    input  logic [COORD_W-1:0]             player_y,
    input  logic [NUM_ENEMY-1:0]           enemy_req,
    input  logic [NUM_ENEMY*COORD_W-1:0]   enemy_x,
    input  logic [NUM_ENEMY*COORD_W-1:0]   enemy_y,
    input  logic [NUM_SLOTS-1:0]           slot_done,
    output logic                           launch,
    output logic [idx_w(NUM_SLOTS)-1:0]    launch_slot,
    output logic [COORD_W-1:0]             launch_x,
    output logic [COORD_W-1:0]             launch_y,
    output logic [idx_w(NUM_ENEMY+1)-1:0]  launch_owner,
    output logic                           player_gnt,
    output logic [NUM_ENEMY-1:0]           enemy_gnt,
    output logic [NUM_SLOTS-1:0]           slot_busy,
    output logic                           pool_full,
    output logic                           player_ready
);

    localparam int SW = idx_w(NUM_SLOTS);
    localparam int EW = idx_w(NUM_ENEMY);
    localparam int OW = idx_w(NUM_ENEMY + 1);
    localparam int LW = idx_w(PLAYER_MAX_LIVE + 1);

    logic [NUM_SLOTS-1:0] busy_reg, busy_next;
    owner_t               owner_reg [NUM_SLOTS];
    logic [LW-1:0]        live_reg, live_next, rel_cnt;
    logic [EW-1:0]        rr_ptr_reg, rr_next;
    logic                 launch_reg, player_gnt_reg;
    logic [NUM_ENEMY-1:0] enemy_gnt_reg;
    logic [SW-1:0]        launch_slot_reg;
    logic [COORD_W-1:0]   launch_x_reg, launch_y_reg;
    logic [OW-1:0]        launch_owner_reg;

    logic                 free_found, cooldown_idle, player_elig, grant, enemy_win, rr_any;
    logic [SW-1:0]        free_idx;
    logic [NUM_ENEMY-1:0] enemy_elig, rr_gnt;
    logic [NUM_SLOTS-1:0] player_rel;
    logic [COORD_W-1:0]   grant_x, grant_y;
    owner_t               grant_owner;
    logic [COORD_W-1:0]   ex_arr [NUM_ENEMY];
    logic [COORD_W-1:0]   ey_arr [NUM_ENEMY];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENEMY; gi++) begin : g_origin
            assign ex_arr[gi] = enemy_x[gi*COORD_W +: COORD_W];
            assign ey_arr[gi] = enemy_y[gi*COORD_W +: COORD_W];
        end
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_release
            assign player_rel[gi] = slot_done[gi] & busy_reg[gi] & (owner_reg[gi] == OWNER_PLAYER);
        end
    endgenerate

`ifdef BULLET_COOLDOWN_EN
    localparam int CW = idx_w(PLAYER_COOLDOWN + 1);
    logic [CW-1:0] cooldown_reg;

    // A fresh player launch reloads the holdoff, overriding the countdown.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            cooldown_reg <= '0;
        else if (player_elig)
            cooldown_reg <= CW'(PLAYER_COOLDOWN);
        else if (cooldown_reg != '0)
            cooldown_reg <= cooldown_reg - CW'(1);
    end
    assign cooldown_idle = (cooldown_reg == '0);
`else
    assign cooldown_idle = 1'b1;
`endif

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy_reg[i]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    assign player_elig = player_req && free_found && (live_reg < LW'(PLAYER_MAX_LIVE))
                         && cooldown_idle && !player_gnt_reg;
    assign enemy_elig  = enemy_req & ~enemy_gnt_reg & {NUM_ENEMY{free_found}};

    rr_arbiter #(
        .N (NUM_ENEMY)
    ) u_rr (
        .req      (enemy_elig),
        .ptr      (rr_ptr_reg),
        .gnt      (rr_gnt),
        .next_ptr (rr_next),
        .any      (rr_any)
    );

    assign enemy_win = rr_any && !player_elig;
    assign grant     = player_elig || rr_any;

    always_comb begin
        grant_x     = player_x;
        grant_y     = player_y;
        grant_owner = OWNER_PLAYER;
        if (!player_elig) begin
            for (int k = 0; k < NUM_ENEMY; k++) begin
                if (rr_gnt[k]) begin
                    grant_x     = ex_arr[k];
                    grant_y     = ey_arr[k];
                    grant_owner = owner_t'(k + 1);
                end
            end
        end
    end

    // Releases see pre-edge busy state, so a freed slot is only reusable next frame.
    always_comb begin
        rel_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (player_rel[i]) rel_cnt = rel_cnt + LW'(1);
        end
        live_next = live_reg + (player_elig ? LW'(1) : LW'(0)) - rel_cnt;
        busy_next = busy_reg & ~slot_done;
        if (grant) busy_next[free_idx] = 1'b1;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            busy_reg         <= '0;
            live_reg         <= '0;
            rr_ptr_reg       <= '0;
            launch_reg       <= 1'b0;
            player_gnt_reg   <= 1'b0;
            enemy_gnt_reg    <= '0;
            launch_slot_reg  <= '0;
            launch_x_reg     <= '0;
            launch_y_reg     <= '0;
            launch_owner_reg <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) owner_reg[i] <= OWNER_PLAYER;
        end else begin
            busy_reg       <= busy_next;
            live_reg       <= live_next;
            launch_reg     <= grant;
            player_gnt_reg <= player_elig;
            enemy_gnt_reg  <= enemy_win ? rr_gnt : '0;
            if (enemy_win) rr_ptr_reg <= rr_next;
            if (grant) begin
                owner_reg[free_idx] <= grant_owner;
                launch_slot_reg     <= free_idx;
                launch_x_reg        <= grant_x;
                launch_y_reg        <= grant_y;
                launch_owner_reg    <= grant_owner[OW-1:0];
            end
        end
    end

    assign launch       = launch_reg;
    assign launch_slot  = launch_slot_reg;
    assign launch_x     = launch_x_reg;
    assign launch_y     = launch_y_reg;
    assign launch_owner = launch_owner_reg;
    assign player_gnt   = player_gnt_reg;
    assign enemy_gnt    = enemy_gnt_reg;
    assign slot_busy    = busy_reg;
    assign pool_full    = &busy_reg;
    assign player_ready = player_elig;

endmodule
